weight_array_ctrl: RTL and testbench

WEIGHT_ARRAY_CTRL -- requirements
Module: weight_array_ctrl

---
 rtl/weight_array_ctrl.sv | 163 ++++++++++++++++
 tb/tb_weight_array_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_array_ctrl.sv
// weight_array_ctrl: loads COL weight buffers column-major from a valid/ready
// weight stream, then streams them out through per-buffer read enables.
// Build option: define WACTRL_SKEW_EN for a skewed (diagonal) drain in which
// buffer i reads during drain cycles i .. i+words-1. Without it, all buffers
// read together for words cycles.
//
// Handshake: a weight word transfers on every cycle where wt_vld && wt_rdy.
// wt_rdy is high only in LOAD (and never in an abort or reset cycle).
// fifo_en is the one-hot write strobe for that same transfer cycle.
// Upstream may drop wt_vld at any time; the gaps do not advance the counters.
module weight_array_ctrl #(
   parameter int COL   = 32,
   parameter int DEPTH = 16,
   localparam int WW   = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [WW-1:0]  words,
   input  logic           wt_vld,
   output logic           wt_rdy,
   input  logic           go,
   output logic [COL-1:0] fifo_en,
   output logic [COL-1:0] out_en,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [2:0]     state_dbg
);

   localparam int CW = (COL > 1) ? $clog2(COL) : 1;
   // Drain counter must reach DEPTH+COL-1 when comparing against i+words.
   localparam int TW = $clog2(DEPTH + COL);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      LOADED = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] words_q;
   logic [WW-1:0] word_cnt;
   logic [CW-1:0] col_cnt;
   logic [TW-1:0] t_cnt;
   logic          start_ok;
   logic          last_word;
   logic          last_col;
   logic          drain_last;

   assign start_ok  = (words != '0) && (words <= WW'(DEPTH));
   assign last_word = (word_cnt == words_q - WW'(1));
   assign last_col  = (col_cnt == CW'(COL - 1));
`ifdef WACTRL_SKEW_EN
   assign drain_last = (t_cnt == TW'(words_q) + TW'(COL - 2));
`else
   assign drain_last = (t_cnt == TW'(words_q) - TW'(1));
`endif

   assign busy      = (state != IDLE) && !rst;
   assign state_dbg = state;

   // State register; reset and abort both return to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode; rst/abort override everything last.
   always_comb begin
      state_nxt = state;
      wt_rdy    = 1'b0;
      fifo_en   = '0;
      out_en    = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (start_ok) state_nxt = LOAD;
               else          err = 1'b1;
            end
         end
         LOAD: begin
            wt_rdy = 1'b1;
            if (wt_vld) begin
               fifo_en = COL'(1) << col_cnt;
               if (last_word && last_col) state_nxt = LOADED;
            end
         end
         LOADED: begin
            if (go) state_nxt = DRAIN;
         end
         DRAIN: begin
`ifdef WACTRL_SKEW_EN
            for (int i = 0; i < COL; i++) begin
               out_en[i] = (t_cnt >= TW'(i)) && (t_cnt < TW'(i) + TW'(words_q));
            end
`else
            out_en = (t_cnt < TW'(words_q)) ? '1 : '0;
`endif
            if (drain_last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (rst || abort) begin
         state_nxt = IDLE;
         wt_rdy    = 1'b0;
         fifo_en   = '0;
         out_en    = '0;
         done      = 1'b0;
         err       = 1'b0;
      end
   end

   // Job counters: latch word count on start, column-major fill, drain time.
   always_ff @(posedge clk) begin
      if (rst) begin
         words_q  <= '0;
         word_cnt <= '0;
         col_cnt  <= '0;
         t_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && start_ok && !abort) begin
                  words_q  <= words;
                  word_cnt <= '0;
                  col_cnt  <= '0;
               end
            end
            LOAD: begin
               if (wt_vld && !abort) begin
                  if (last_word) begin
                     word_cnt <= '0;
                     if (!last_col) col_cnt <= col_cnt + CW'(1);
                  end else begin
                     word_cnt <= word_cnt + WW'(1);
                  end
               end
            end
            LOADED: begin
               if (go) t_cnt <= '0;
            end
            DRAIN: begin
               t_cnt <= t_cnt + TW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_array_ctrl.sv
// Directed bench for weight_array_ctrl at COL=4, DEPTH=8.
// Expectations follow whichever drain mode WACTRL_SKEW_EN selects.
module tb_weight_array_ctrl;

   localparam int COL   = 4;
   localparam int DEPTH = 8;
   localparam int WW    = $clog2(DEPTH + 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_LOADED = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic           clk;
   logic           rst;
   logic           start;
   logic           abort;
   logic [WW-1:0]  words;
   logic           wt_vld;
   logic           wt_rdy;
   logic           go;
   logic [COL-1:0] fifo_en;
   logic [COL-1:0] out_en;
   logic           busy;
   logic           done;
   logic           err;
   logic [2:0]     state_dbg;

   int             vectors     = 0;
   int             miscompares = 0;
   logic [COL-1:0] exp_q[$];
   logic [COL-1:0] e;

   weight_array_ctrl #(.COL(COL), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .words     (words),
      .wt_vld    (wt_vld),
      .wt_rdy    (wt_rdy),
      .go        (go),
      .fifo_en   (fifo_en),
      .out_en    (out_en),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .state_dbg (state_dbg)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are then driven.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Feeds a full column-major load starting in the first LOAD cycle.
   // With gaps, wt_vld alternates 1,0 so every second cycle is idle.
   task automatic run_load(input int w, input bit gaps, input string tag);
      int n;
      exp_q.delete();
      for (int c = 0; c < COL; c++) begin
         for (int k = 0; k < w; k++) begin
            exp_q.push_back(COL'(1) << c);
            if (gaps) exp_q.push_back('0);
         end
      end
      n = exp_q.size();
      for (int j = 0; j < n; j++) begin
         wt_vld = gaps ? ((j % 2) == 0) : 1'b1;
         settle();
         e = exp_q.pop_front();
         chk(tag, 32'(fifo_en), 32'(e));
         if (j == 0) chk({tag, "_rdy"}, 32'(wt_rdy), 32'd1);
         cyc();
      end
   endtask

   initial begin
      // Reset with every request input active: all outputs must stay low.
      rst = 1'b1; start = 1'b1; words = WW'(3); abort = 1'b0;
      wt_vld = 1'b1; go = 1'b1;
      cyc();
      settle();
      chk("rst_wt_rdy",  32'(wt_rdy),  32'd0);
      chk("rst_fifo_en", 32'(fifo_en), 32'd0);
      chk("rst_out_en",  32'(out_en),  32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_err",     32'(err),     32'd0);
      cyc();
      chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      rst = 1'b0; start = 1'b0; wt_vld = 1'b0; go = 1'b0;
      settle();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_err",  32'(err),  32'd0);

      // Illegal word counts: words=0 then words=DEPTH+1.
      start = 1'b1; words = WW'(0);
      settle();
      chk("err_w0", 32'(err), 32'd1);
      chk("err_w0_busy", 32'(busy), 32'd0);
      cyc();
      start = 1'b0;
      settle();
      chk("err_w0_clear", 32'(err), 32'd0);
      chk("err_w0_state", 32'(state_dbg), 32'(ST_IDLE));
      start = 1'b1; words = WW'(9);
      settle();
      chk("err_w9", 32'(err), 32'd1);
      cyc();
      start = 1'b0;
      settle();
      chk("err_w9_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("err_w9_busy",  32'(busy), 32'd0);

      // go outside LOADED is ignored.
      go = 1'b1;
      cyc();
      go = 1'b0;
      settle();
      chk("go_idle_state", 32'(state_dbg), 32'(ST_IDLE));

      // abort together with a legal start in IDLE: abort wins.
      start = 1'b1; words = WW'(3); abort = 1'b1;
      settle();
      chk("abort_start_err", 32'(err), 32'd0);
      cyc();
      start = 1'b0; abort = 1'b0;
      settle();
      chk("abort_start_state", 32'(state_dbg), 32'(ST_IDLE));

      // Contiguous load, words=3: 0001 x3, 0010 x3, 0100 x3, 1000 x3.
      start = 1'b1; words = WW'(3);
      settle();
      chk("start3_err", 32'(err), 32'd0);
      cyc();
      start = 1'b0;
      settle();
      chk("load_state", 32'(state_dbg), 32'(ST_LOAD));
      chk("load_busy",  32'(busy), 32'd1);
      run_load(3, 1'b0, "load3");
      wt_vld = 1'b1;
      settle();
      chk("loaded_state",   32'(state_dbg), 32'(ST_LOADED));
      chk("loaded_wt_rdy",  32'(wt_rdy),    32'd0);
      chk("loaded_fifo_en", 32'(fifo_en),   32'd0);
      wt_vld = 1'b0;
      cyc();
      cyc();
      settle();
      chk("loaded_wait_state", 32'(state_dbg), 32'(ST_LOADED));

      // Drain of the words=3 job.
      go = 1'b1;
      settle();
      chk("go_out_en", 32'(out_en), 32'd0);
      cyc();
      go = 1'b0; wt_vld = 1'b1;
      exp_q.delete();
`ifdef WACTRL_SKEW_EN
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0011); exp_q.push_back(4'b0111);
      exp_q.push_back(4'b1110); exp_q.push_back(4'b1100); exp_q.push_back(4'b1000);
`else
      exp_q.push_back(4'b1111); exp_q.push_back(4'b1111); exp_q.push_back(4'b1111);
`endif
      while (exp_q.size() != 0) begin
         settle();
         e = exp_q.pop_front();
         chk("drain_out_en",  32'(out_en),  32'(e));
         chk("drain_fifo_en", 32'(fifo_en), 32'd0);
         cyc();
      end
      wt_vld = 1'b0;
      settle();
      chk("done_pulse",  32'(done),      32'd1);
      chk("done_busy",   32'(busy),      32'd1);
      chk("done_state",  32'(state_dbg), 32'(ST_DONE));
      chk("done_out_en", 32'(out_en),    32'd0);
      cyc();
      settle();
      chk("after_done_done",  32'(done),      32'd0);
      chk("after_done_busy",  32'(busy),      32'd0);
      chk("after_done_state", 32'(state_dbg), 32'(ST_IDLE));

      // Gapped load, words=3, wt_vld toggling 1,0,...
      start = 1'b1; words = WW'(3);
      cyc();
      start = 1'b0;
      run_load(3, 1'b1, "gap3");
      settle();
      chk("gap_loaded_state", 32'(state_dbg), 32'(ST_LOADED));

      // Drain then abort at t=2.
      go = 1'b1;
      cyc();
      go = 1'b0;
      settle();
`ifdef WACTRL_SKEW_EN
      chk("abort_t0_out_en", 32'(out_en), 32'h1);
`else
      chk("abort_t0_out_en", 32'(out_en), 32'hf);
`endif
      cyc();
      settle();
`ifdef WACTRL_SKEW_EN
      chk("abort_t1_out_en", 32'(out_en), 32'h3);
`else
      chk("abort_t1_out_en", 32'(out_en), 32'hf);
`endif
      cyc();
      abort = 1'b1;
      settle();
      chk("abort_t2_state",  32'(state_dbg), 32'(ST_DRAIN));
      chk("abort_t2_out_en", 32'(out_en),    32'd0);
      chk("abort_t2_done",   32'(done),      32'd0);
      cyc();
      abort = 1'b0;
      settle();
      chk("abort_next_state",  32'(state_dbg), 32'(ST_IDLE));
      chk("abort_next_busy",   32'(busy),      32'd0);
      chk("abort_next_done",   32'(done),      32'd0);
      chk("abort_next_out_en", 32'(out_en),    32'd0);

      // Reset in the middle of a words=1 load.
      start = 1'b1; words = WW'(1);
      cyc();
      start = 1'b0; wt_vld = 1'b1;
      settle();
      chk("midload_fe0", 32'(fifo_en), 32'h1);
      cyc();
      settle();
      chk("midload_fe1", 32'(fifo_en), 32'h2);
      cyc();
      rst = 1'b1;
      settle();
      chk("midrst_wt_rdy",  32'(wt_rdy),  32'd0);
      chk("midrst_fifo_en", 32'(fifo_en), 32'd0);
      chk("midrst_busy",    32'(busy),    32'd0);
      cyc();
      rst = 1'b0; wt_vld = 1'b0;
      settle();
      chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("midrst_done",  32'(done),      32'd0);

      // New job accepted after the reset; load restarts at column 0.
      start = 1'b1; words = WW'(1);
      cyc();
      start = 1'b0;
      settle();
      chk("restart_state", 32'(state_dbg), 32'(ST_LOAD));
      run_load(1, 1'b0, "load1");
      wt_vld = 1'b0;
      settle();
      chk("restart_loaded", 32'(state_dbg), 32'(ST_LOADED));
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      settle();
      chk("abort_loaded_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("abort_loaded_done",  32'(done),      32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
